// File: rtl/reorder_buffer_param.sv
// Parametrised reorder buffer: in-order commit, CDB result capture,
// precise exception flush and two combinational operand lookups.
module reorder_buffer_param #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int NUM_CDB = 4,
  localparam int CW = DATA_W + TAG_W + 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  append,
  input  logic [REG_AW-1:0]     DestReg,
  output logic                  full,
  output logic                  empty,
  output logic [TAG_W:0]        count,
  output logic [TAG_W-1:0]      ROBTail,
  input  logic [NUM_CDB*CW-1:0] CDB,
  input  logic [TAG_W-1:0]      QTag0,
  input  logic [TAG_W-1:0]      QTag1,
  output logic                  QReady0,
  output logic                  QReady1,
  output logic [DATA_W-1:0]     QValue0,
  output logic [DATA_W-1:0]     QValue1,
  output logic [REG_AW-1:0]     WA,
  output logic                  WE,
  output logic [DATA_W-1:0]     WD,
  output logic                  ExcValid,
  output logic [TAG_W-1:0]      ExcTag
);

  logic [TAG_W:0]      head;
  logic [TAG_W:0]      tail;
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    done;
  logic [DEPTH-1:0]    exc;
  logic [REG_AW-1:0]   dest  [DEPTH];
  logic [DATA_W-1:0]   value [DEPTH];

  logic [TAG_W-1:0]    hidx;
  logic [TAG_W-1:0]    tidx;
  logic                h_done;
  logic                commit;
  logic                flush;
  logic                push;

  assign hidx    = head[TAG_W-1:0];
  assign tidx    = tail[TAG_W-1:0];
  assign full    = (head[TAG_W] != tail[TAG_W]) && (hidx == tidx);
  assign empty   = (head == tail);
  assign count   = tail - head;
  assign ROBTail = tidx;

  assign h_done = busy[hidx] && done[hidx];
  assign commit = h_done && !exc[hidx] && !empty;
  assign flush  = h_done && exc[hidx];
  assign push   = append && !full && !flush;

  logic [TAG_W-1:0]    c_tag [NUM_CDB];
  logic [NUM_CDB-1:0]  c_vld;
  logic [NUM_CDB-1:0]  c_exc;
  logic [DATA_W-1:0]   c_val [NUM_CDB];

  for (genvar c = 0; c < NUM_CDB; c++) begin : g_ch
    assign c_tag[c] = CDB[c*CW +: TAG_W];
    assign c_vld[c] = CDB[c*CW + TAG_W];
    assign c_exc[c] = CDB[c*CW + TAG_W + 1];
    assign c_val[c] = CDB[c*CW + TAG_W + 2 +: DATA_W];
  end

  logic [DEPTH-1:0]    cap;
  logic [DEPTH-1:0]    cap_exc;
  logic [DATA_W-1:0]   cap_val [DEPTH];

  // Ascending scan so the highest channel wins on a shared tag;
  // the entry retiring this cycle no longer accepts results.
  always_comb begin
    cap     = '0;
    cap_exc = '0;
    for (int i = 0; i < DEPTH; i++) cap_val[i] = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (c_vld[c] && busy[c_tag[c]] &&
          !(commit && (c_tag[c] == hidx))) begin
        cap[c_tag[c]]     = 1'b1;
        cap_exc[c_tag[c]] = c_exc[c];
        cap_val[c_tag[c]] = c_val[c];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      head     <= '0;
      tail     <= '0;
      busy     <= '0;
      done     <= '0;
      exc      <= '0;
      WA       <= '0;
      WE       <= 1'b0;
      WD       <= '0;
      ExcValid <= 1'b0;
      ExcTag   <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      busy     <= '0;
      done     <= '0;
      exc      <= '0;
      WA       <= '0;
      WE       <= 1'b0;
      WD       <= '0;
      ExcValid <= 1'b1;
      ExcTag   <= hidx;
    end else begin
      ExcValid <= 1'b0;
      WE       <= commit;
      WA       <= commit ? dest[hidx]  : '0;
      WD       <= commit ? value[hidx] : '0;
      done     <= done | cap;
      exc      <= (exc & ~cap) | cap_exc;
      if (commit) begin
        busy[hidx] <= 1'b0;
        head       <= head + (TAG_W+1)'(1);
      end
      if (push) begin
        busy[tidx] <= 1'b1;
        done[tidx] <= 1'b0;
        exc[tidx]  <= 1'b0;
        tail       <= tail + (TAG_W+1)'(1);
      end
    end
  end

  // Payload storage carries no reset; it is only visible once BUSY/DONE set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cap[i]) value[i] <= cap_val[i];
    end
    if (push) dest[tidx] <= DestReg;
  end

  assign QReady0 = busy[QTag0] && done[QTag0] && !exc[QTag0];
  assign QReady1 = busy[QTag1] && done[QTag1] && !exc[QTag1];
  assign QValue0 = QReady0 ? value[QTag0] : '0;
  assign QValue1 = QReady1 ? value[QTag1] : '0;

endmodule
